dadda_mul_8x8: RTL and testbench
================================

// Module: dadda_mul_8x8
// PURPOSE
//  Unsigned 8x8 Dadda-tree multiplier with a registered 16-bit product.
//  Partial products are reduced with half/full adders (carry-save) through
//  Dadda heights 8->6->4->3->2, then summed by a final carry-propagate adder.
//  Datapath arithmetic leaf; the registered output gives the block a fixed
//  one-cycle latency.
// PARAMETERS
//  N  8   width of operand A (fixed; not a general-width generator)
//  M  8   width of operand B (fixed)
//  Product width is N+M = 16.
// PORTS
//  clk  in   1   single clock; all state updates on rising edge
//  rst  in   1   synchronous, active-high reset
//  A    in   8   multiplicand, unsigned
//  B    in   8   multiplier, unsigned
//  y    out  16  product A*B, unsigned, registered
// BEHAVIOUR
//  - Clocking: one clock; reset is synchronous and active-high.
//  - Reset: while rst=1 at a rising clk edge, y <= 16'h0000.
//    rst has priority over new operand capture.
//  - Latency: when rst=0, y <= A*B at every rising edge from A and B
//    present before that edge. Latency is 1 cycle, with a new result every
//    cycle. There is no handshake and no valid signal; the block is fully
//    pipelined at depth 1.
//  - Partial products: pp[i][j] = A[j] & B[i], for column weight i+j,
//    with i,j in 0..7.
//  - Reduction:
//    - Dadda stages with target heights 6, 4, 3, 2.
//    - At each stage, use the minimum number of HA/FA per column needed to
//      bring the column height to the target, including carries arriving
//      from the column below.
//    - FA: s = a^b^c, co = maj(a,b,c). HA: s = a^b, co = a&b.
//  - Final adder: 16-bit ripple-carry (or equivalent CPA) on the two
//    remaining rows. The carry out of bit 15 is always 0 and is discarded.
//  - Result is exact, with no overflow possible: max 255*255 = 65025.
//  - All logic between the operand inputs and the y register is
//    combinational; no latches.
//  - X on inputs is not required to be handled; outputs follow the
//    operands one edge later.
//  - Reset mid-stream: the edge with rst=1 yields 0. The first edge after
//    rst falls yields the product of the operands present at that edge.
// TESTING
//  1. rst=1 for 2 cycles, with any A,B -> y==0 after each edge.
//  2. A=250, B=250 -> y==62500 (16'hF424) one edge later.
//  3. A=255, B=255 -> y==65025 (16'hFE01); A=0, B=255 -> y==0;
//     A=1, B=173 -> y==173.
//  4. Back-to-back: A=128,B=2 then A=15,B=17 on consecutive cycles ->
//     y==256, then y==255 on successive edges (1-cycle latency, no stall).
//  5. Reset mid-stream: A=200,B=3 with rst=1 -> y==0; drop rst -> y==600
//     next edge.
//  6. Self-check: 1000 random A,B pairs, compared against the A*B model
//     delayed 1 cycle; plus an exhaustive 65536-pair sweep with zero
//     mismatches.

Source files
------------

// File: rtl/dadda_mul_8x8.sv
// Unsigned 8x8 Dadda multiplier: partial-product matrix reduced through heights
// 8->6->4->3->2 with half/full adders, ripple-carry final add, registered product.
module dadda_mul_8x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] y
);

  localparam int NCOL   = 16;
  localparam int NSTAGE = 4;

  // Full adders placed in stage s, column c (stages target heights 6, 4, 3, 2).
  function automatic int fa_cnt(input int s, input int c);
    case (s)
      0:       return (c >= 7 && c <= 9) ? 1 : 0;
      1:       return (c == 5 || c == 11) ? 1 : ((c >= 6 && c <= 10) ? 2 : 0);
      2:       return (c >= 4 && c <= 12) ? 1 : 0;
      3:       return (c >= 3 && c <= 13) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Half adders placed in stage s, column c.
  function automatic int ha_cnt(input int s, input int c);
    case (s)
      0:       return (c >= 6 && c <= 8) ? 1 : 0;
      1:       return (c == 4 || c == 5) ? 1 : 0;
      2:       return (c == 3) ? 1 : 0;
      3:       return (c == 2) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Number of bits in column c at the input of stage s (s = NSTAGE is the final pair of rows).
  function automatic int col_height(input int s, input int c);
    int h;
    h = (c < 8) ? c + 1 : ((c < 15) ? 15 - c : 0);
    for (int k = 0; k < s; k++) begin
      h = h - 2 * fa_cnt(k, c) - ha_cnt(k, c);
      if (c > 0) h = h + fa_cnt(k, c - 1) + ha_cnt(k, c - 1);
    end
    return h;
  endfunction

  // Each stage is a flat vector with columns packed LSB-first; this is where column c starts.
  function automatic int col_offset(input int s, input int c);
    int ofs;
    ofs = 0;
    for (int k = 0; k < c; k++) ofs = ofs + col_height(s, k);
    return ofs;
  endfunction

  localparam int W0 = col_offset(0, NCOL);
  localparam int W1 = col_offset(1, NCOL);
  localparam int W2 = col_offset(2, NCOL);
  localparam int W3 = col_offset(3, NCOL);
  localparam int W4 = col_offset(4, NCOL);

  logic [W0-1:0] pp;
  logic [W1-1:0] st1;
  logic [W2-1:0] st2;
  logic [W3-1:0] st3;
  logic [W4-1:0] st4;
  logic [15:0]   row_a;
  logic [15:0]   row_b;
  logic [15:0]   prod_d;
  logic [15:0]   y_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < 8; gj++) begin : g_pp_col
      localparam int COL = gi + gj;
      localparam int POS = col_offset(0, COL) + gi - ((COL > 7) ? COL - 7 : 0);
      assign pp[POS] = A[gj] & B[gi];
    end
  end

  for (genvar gs = 0; gs < NSTAGE; gs++) begin : g_stage
    localparam int WI = col_offset(gs, NCOL);
    localparam int WO = col_offset(gs + 1, NCOL);
    logic [WI-1:0] cur;
    logic [WO-1:0] nxt;

    if (gs == 0) begin : g_src0
      assign cur = pp;
    end else if (gs == 1) begin : g_src1
      assign cur = st1;
    end else if (gs == 2) begin : g_src2
      assign cur = st2;
    end else begin : g_src3
      assign cur = st3;
    end

    if (gs == 0) begin : g_dst0
      assign st1 = nxt;
    end else if (gs == 1) begin : g_dst1
      assign st2 = nxt;
    end else if (gs == 2) begin : g_dst2
      assign st3 = nxt;
    end else begin : g_dst3
      assign st4 = nxt;
    end

    // Output column order: carries from the column below, FA sums, HA sums, untouched bits.
    for (genvar gc = 0; gc < NCOL; gc++) begin : g_col
      localparam int IB    = col_offset(gs, gc);
      localparam int OB    = col_offset(gs + 1, gc);
      localparam int OB_UP = col_offset(gs + 1, gc + 1);
      localparam int CIN   = (gc > 0) ? fa_cnt(gs, gc - 1) + ha_cnt(gs, gc - 1) : 0;
      localparam int NFA   = fa_cnt(gs, gc);
      localparam int NHA   = ha_cnt(gs, gc);
      localparam int NPASS = col_height(gs, gc) - 3 * NFA - 2 * NHA;

      for (genvar gi = 0; gi < NFA; gi++) begin : g_fa
        localparam int I = IB + 3 * gi;
        assign nxt[OB + CIN + gi] = cur[I] ^ cur[I + 1] ^ cur[I + 2];
        assign nxt[OB_UP + gi]    = (cur[I] & cur[I + 1]) | (cur[I] & cur[I + 2]) |
                                    (cur[I + 1] & cur[I + 2]);
      end

      for (genvar gi = 0; gi < NHA; gi++) begin : g_ha
        localparam int I = IB + 3 * NFA + 2 * gi;
        assign nxt[OB + CIN + NFA + gi] = cur[I] ^ cur[I + 1];
        assign nxt[OB_UP + NFA + gi]    = cur[I] & cur[I + 1];
      end

      for (genvar gi = 0; gi < NPASS; gi++) begin : g_pass
        assign nxt[OB + CIN + NFA + NHA + gi] = cur[IB + 3 * NFA + 2 * NHA + gi];
      end
    end
  end

  // Split the height-2 matrix into two addend rows; empty slots are zero.
  for (genvar gc = 0; gc < NCOL; gc++) begin : g_rows
    localparam int H   = col_height(NSTAGE, gc);
    localparam int OFS = col_offset(NSTAGE, gc);
    if (H >= 1) begin : g_a
      assign row_a[gc] = st4[OFS];
    end else begin : g_a0
      assign row_a[gc] = 1'b0;
    end
    if (H >= 2) begin : g_b
      assign row_b[gc] = st4[OFS + 1];
    end else begin : g_b0
      assign row_b[gc] = 1'b0;
    end
  end

  always_comb begin
    logic carry;
    carry  = 1'b0;
    prod_d = '0;
    for (int k = 0; k < 16; k++) begin
      prod_d[k] = row_a[k] ^ row_b[k] ^ carry;
      carry     = (row_a[k] & row_b[k]) | (carry & (row_a[k] ^ row_b[k]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 16'h0000;
    end else begin
      y_q <= prod_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_dadda_mul_8x8.sv
// Self-checking bench for dadda_mul_8x8: directed cases, reset mixing, random pairs
// and an exhaustive operand sweep against an integer-multiply model.
module tb_dadda_mul_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A   = 8'd0;
  logic [7:0]  B   = 8'd0;
  logic [15:0] y;

  int checks   = 0;
  int failures = 0;

  dadda_mul_8x8 dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .y  (y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp_y);
    checks++;
    if (got !== exp_y) begin
      failures++;
      $display("FAIL %s: y=%0d (0x%h) expected %0d (0x%h)", tag, got, got, exp_y, exp_y);
    end
  endtask

  // One clock: present operands mid-cycle, let the edge capture them, compare after it.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic r, input bit verbose);
    logic [15:0] exp_y;
    @(negedge clk);
    A = a;
    B = b;
    rst = r;
    exp_y = r ? 16'd0 : 16'(int'(a) * int'(b));
    @(posedge clk);
    #1;
    check_eq(tag, y, exp_y);
    if (verbose) $display("txn %-10s rst=%0b A=%3d B=%3d y=%0d", tag, r, a, b, y);
  endtask

  initial begin
    step("reset0", 8'd255, 8'd255, 1'b1, 1'b1);
    step("reset1", 8'd37,  8'd91,  1'b1, 1'b1);

    step("250x250", 8'd250, 8'd250, 1'b0, 1'b1);
    step("255x255", 8'd255, 8'd255, 1'b0, 1'b1);
    step("0x255",   8'd0,   8'd255, 1'b0, 1'b1);
    step("1x173",   8'd1,   8'd173, 1'b0, 1'b1);
    step("128x2",   8'd128, 8'd2,   1'b0, 1'b1);
    step("15x17",   8'd15,  8'd17,  1'b0, 1'b1);
    step("mid_rst", 8'd200, 8'd3,   1'b1, 1'b1);
    step("post_rst",8'd200, 8'd3,   1'b0, 1'b1);
    step("255x1",   8'd255, 8'd1,   1'b0, 1'b1);
    step("170x85",  8'd170, 8'd85,  1'b0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      step("random", 8'($urandom_range(255)), 8'($urandom_range(255)),
           ($urandom_range(15) == 0), 1'b0);
    end
    $display("txn random    1000 pairs done, failures so far=%0d", failures);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step("sweep", 8'(a), 8'(b), 1'b0, 1'b0);
      end
    end
    $display("txn sweep     65536 pairs done, failures so far=%0d", failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
